uio_bus_arbiter: RTL
====================

Name: uio_bus_arbiter

Overview:
Shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) of the top-level tile between NREQ internal requesters. Each transaction is one byte, either a write (drive) or a read (sample). A round-robin arbiter grants requesters in turn, and a sequencer inserts bus-turnaround gaps on direction changes so the pad drivers never contend with an external device. The block sits between the user logic and the uio pins of the tile wrapper.

Parameters:
NREQ, 4, number of requesters (2..8).
TURN_CYC, 1, turnaround cycles with uio_oe=0x00 inserted on a direction change (0..7; 0 = no TURN state).
HOLD_CYC, 2, cycles the bus is driven or sampled per transaction (1..15).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req  in  NREQ  per-requester transaction request, level.
req_we  in  NREQ  1 = write, 0 = read; sampled at arbitration only.
req_wdata  in  8*NREQ  write byte, requester i at [8i+7:8i]; sampled at arbitration only.
gnt  out  NREQ  one-hot owner, high from first TURN/XFER cycle through last XFER cycle.
done  out  NREQ  one-cycle completion pulse to the owner.
rdata  out  8  last read byte; valid in the done cycle and held until the next read completes.
busy  out  1  high in any state other than IDLE.
uio_in  in  8  pad input path.
uio_out  out  8  pad output path.
uio_oe  out  8  pad enable, all bits identical (0x00 or 0xFF).

Behaviour:
- Reset (synchronous): state IDLE, gnt=0, done=0, rdata=0x00, uio_out=0x00, uio_oe=0x00, busy=0, round-robin pointer=0, parked direction=read. Reset mid-transaction aborts it at the next edge, with no done pulse.
- States: IDLE, TURN, XFER, DONE.
- IDLE: if req is nonzero, select the first asserted index starting at the pointer and searching upward cyclically. Latch index, we and wdata.
  - If the latched direction differs from the parked direction and TURN_CYC>0, go to TURN. Otherwise go to XFER.
  - gnt for the selected index goes high on the same edge.
- TURN: uio_oe=0x00 for exactly TURN_CYC cycles, then XFER. Parked direction is updated on entry to TURN.
- XFER write: uio_oe=0xFF and uio_out=latched wdata for HOLD_CYC cycles.
- XFER read: uio_oe=0x00 for HOLD_CYC cycles. uio_in is captured into rdata on the final XFER edge.
- DONE: one cycle. gnt=0 and done[idx]=1. The pointer becomes (idx+1) mod NREQ. Next state is IDLE.
  - No arbitration occurs in DONE. A requester that keeps req high re-enters arbitration in the following IDLE cycle with the lowest priority.
- Parking: after a write, uio_oe stays 0xFF and uio_out holds the data through DONE and IDLE until a read's TURN/XFER or reset. After a read, uio_oe stays 0x00.
- Transaction length: 1 arbitration cycle + (TURN_CYC if direction changes) + HOLD_CYC + 1 DONE cycle. With defaults and the same direction, done asserts 3 cycles after req is seen in IDLE.
- req should be held until done. If req drops while granted, the transaction still completes and done still pulses (no abort). Changes to req_we or req_wdata after arbitration are ignored.
- Simultaneous requests: exactly one grant, chosen by the pointer. gnt is never multi-hot, and done is never asserted to a non-owner.
- Indices >= NREQ are never granted. Requests from non-owners are ignored until IDLE.

Test Plan:
- Reset: assert rst for 2 cycles with req=0xF.
  -> gnt=0, done=0, uio_oe=0x00, uio_out=0x00, rdata=0x00, busy=0 throughout.
- Write from reset: req[2]=1, we=1, wdata=0xA5, defaults.
  -> cycle+1: gnt=0100, uio_oe=0x00 (TURN).
  -> cycles +2..+3: uio_oe=0xFF, uio_out=0xA5.
  -> cycle+4: done=0100.
  -> afterwards uio_oe stays 0xFF.
- Read after that write: req[1], we=0, uio_in=0x3C.
  -> one TURN cycle with uio_oe=0x00, then 2 XFER cycles with uio_oe=0x00.
  -> done=0010 with rdata=0x3C; rdata is held at 0x3C afterwards.
- Fairness: req=1111, all reads, held high.
  -> grant order 0,1,2,3,0,1, with done pulses every 4 cycles.
  -> gnt always one-hot or zero.
- Abort: rst asserted during the second XFER cycle of a write to requester 3.
  -> next cycle gnt=0, uio_oe=0x00, no done[3].
  -> pointer restarts at 0.
- Dropped request: req[0] deasserted on the first XFER cycle of a write 0x5A.
  -> 0x5A still driven for 2 cycles, done[0] pulses.
  -> IDLE afterwards, with no new grant.

Source files
------------

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin sharing of the 8-bit bidirectional uio pad bus
// among NREQ requesters. Each grant moves one byte (write = drive, read = sample).
// A turnaround gap with the pads released is inserted whenever the bus
// direction flips, so the pad drivers never fight an external device.
module uio_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int TURN_CYC = 1,
  parameter int HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              busy,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_XFER, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            we_q, we_d;
  logic            park_we_q, park_we_d;  // 1 = bus parked driving
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      out_q, out_d;
  logic [7:0]      oe_q, oe_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;

  // arbitration candidates
  logic            sel_vld;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   cand;
  logic            sel_we;
  logic [7:0]      sel_wdata;
  // shared XFER entry controls
  logic            start_xfer;
  logic            xfer_we;
  logic [7:0]      xfer_data;

  // Round-robin pick: first asserted request at or cyclically above the pointer.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!sel_vld && req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
    sel_we    = req_we[sel_idx];
    sel_wdata = req_wdata[{sel_idx, 3'b000} +: 8];
  end

  // Next-state and registered-output logic for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ptr_d      = ptr_q;
    we_d       = we_q;
    park_we_d  = park_we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    out_d      = out_q;
    oe_d       = oe_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    start_xfer = 1'b0;
    xfer_we    = we_q;
    xfer_data  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          idx_d          = sel_idx;
          we_d           = sel_we;
          wdata_d        = sel_wdata;
          park_we_d      = sel_we;
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          if (TURN_CYC > 0 && sel_we != park_we_q) begin
            // release the pads before the direction flips
            state_d = S_TURN;
            cnt_d   = 4'(TURN_CYC - 1);
            oe_d    = 8'h00;
          end else begin
            start_xfer = 1'b1;
            xfer_we    = sel_we;
            xfer_data  = sel_wdata;
          end
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd0) start_xfer = 1'b1;
        else               cnt_d = cnt_q - 4'd1;
      end
      S_XFER: begin
        if (cnt_q == 4'd0) begin
          state_d       = S_DONE;
          gnt_d         = '0;
          done_d[idx_q] = 1'b1;
          if (!we_q) rdata_d = uio_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        // the finished owner drops to lowest priority
        ptr_d   = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (start_xfer) begin
      state_d = S_XFER;
      cnt_d   = 4'(HOLD_CYC - 1);
      oe_d    = xfer_we ? 8'hFF : 8'h00;
      if (xfer_we) out_d = xfer_data;
    end
  end

  // State register; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      we_q      <= 1'b0;
      park_we_q <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      out_q     <= '0;
      oe_q      <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      park_we_q <= park_we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign busy    = (state_q != S_IDLE);
  assign uio_out = out_q;
  assign uio_oe  = oe_q;

endmodule
